// File: rtl/fcnt_pkg.sv
// Shared types and constants for the RF frequency counter controller.
// The state enum is also what the top drives onto its debug port.
package fcnt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        MEAS = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } fcnt_state_t;

    localparam int F_W       = 14;
    localparam int F_MAX     = 16383;
    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/fcnt_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the go cycle, so done pulses exactly W cycles after go.
module fcnt_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic [W-1:0] q,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  den_r;
    logic [CW-1:0] cnt;
    logic          running;

    logic [W-1:0]  rem_in;
    logic [W-1:0]  quo_in;
    logic [W-1:0]  den_in;
    logic [W:0]    trial;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;

    // One restoring step; on go it works straight from the new operands.
    always_comb begin
        rem_in  = go ? '0  : rem;
        quo_in  = go ? num : quo;
        den_in  = go ? den : den_r;
        trial   = {rem_in, quo_in[W-1]};
        rem_nxt = trial[W-1:0];
        quo_nxt = {quo_in[W-2:0], 1'b0};
        if (trial >= {1'b0, den_in}) begin
            rem_nxt = trial[W-1:0] - den_in;
            quo_nxt = {quo_in[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            den_r   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                rem     <= rem_nxt;
                quo     <= quo_nxt;
                den_r   <= den;
                cnt     <= CW'(W - 1);
                running <= 1'b1;
            end else if (running) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign q = quo;

endmodule

// File: rtl/fcounter_ctrl.sv
// Frequency counter measurement controller: synchronizes sig, times M rising
// edges in clk cycles and divides M*F_CLK by that count to get hundreds of Hz.
module fcounter_ctrl
    import fcnt_pkg::*;
#(
    parameter int M           = 8000,
    parameter int F_CLK       = 40000,
    parameter int TIMEOUT_CYC = 8000000,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sig,
    input  logic           start,
    input  logic           cont,
    output logic [F_W-1:0] f,
    output logic           f_valid,
    output logic           busy,
    output logic           timeout,
    output logic           sat,
    output logic [2:0]     state_dbg
);

    localparam logic [CNT_W-1:0] NUM     = CNT_W'(M * F_CLK);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] Q_MAX   = CNT_W'(F_MAX);

    fcnt_state_t      state;
    logic             sync1, sync2, sync3;
    logic             sig_edge;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] tcnt;
    logic             div_go;
    logic [CNT_W-1:0] div_q;
    logic             div_done;

    // Two-flop synchronizer plus a registered rising-edge detector (3 cycles total).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            sig_edge <= 1'b0;
        end else begin
            sync1    <= sig;
            sync2    <= sync1;
            sync3    <= sync2;
            sig_edge <= sync2 & ~sync3;
        end
    end

    fcnt_div #(.W(CNT_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .go   (div_go),
        .num  (NUM),
        .den  (n),
        .q    (div_q),
        .done (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n       <= '0;
            k       <= '0;
            tcnt    <= '0;
            div_go  <= 1'b0;
            f       <= '0;
            f_valid <= 1'b0;
            timeout <= 1'b0;
            sat     <= 1'b0;
        end else begin
            f_valid <= 1'b0;
            div_go  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || cont) begin
                        state <= ARM;
                        n     <= '0;
                        k     <= '0;
                        tcnt  <= '0;
                    end
                end
                ARM, MEAS: begin
                    tcnt <= tcnt + 1'b1;
                    // Timeout has priority over a coincident edge.
                    if (tcnt == TO_LAST) begin
                        state   <= DONE;
                        f       <= '0;
                        timeout <= 1'b1;
                        sat     <= 1'b0;
                        f_valid <= 1'b1;
                    end else if (state == ARM) begin
                        if (sig_edge) begin
                            state <= MEAS;
                            n     <= '0;
                            k     <= '0;
                        end
                    end else begin
                        n <= n + 1'b1;
                        if (sig_edge) begin
                            if (k == K_LAST) begin
                                state  <= DIV;
                                div_go <= 1'b1;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state   <= DONE;
                        f_valid <= 1'b1;
                        timeout <= 1'b0;
                        if (div_q > Q_MAX) begin
                            f   <= F_W'(F_MAX);
                            sat <= 1'b1;
                        end else begin
                            f   <= div_q[F_W-1:0];
                            sat <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (cont) begin
                        state <= ARM;
                        n     <= '0;
                        k     <= '0;
                        tcnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fcounter_ctrl.sv
// Bench for fcounter_ctrl with M=8, F_CLK=40000, TIMEOUT_CYC=4096, clk period 20.
// Expected results are queued as {timeout, sat, f}; a negedge monitor pops on f_valid.
module tb_fcounter_ctrl;

    localparam int     M           = 8;
    localparam int     F_CLK       = 40000;
    localparam int     TIMEOUT_CYC = 4096;
    localparam int     CNT_W       = 32;
    localparam longint NUM         = longint'(M) * longint'(F_CLK);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_MEAS = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        start;
    logic        cont;
    logic [13:0] f;
    logic        f_valid;
    logic        busy;
    logic        timeout;
    logic        sat;
    logic [2:0]  state_dbg;

    int          tests  = 0;
    int          fails  = 0;
    int          nvalid = 0;
    int          sig_half = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    fcounter_ctrl #(
        .M           (M),
        .F_CLK       (F_CLK),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .start     (start),
        .cont      (cont),
        .f         (f),
        .f_valid   (f_valid),
        .busy      (busy),
        .timeout   (timeout),
        .sat       (sat),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    always #10 clk = ~clk;

    initial begin
        if (NUM >= (64'd1 << CNT_W)) begin
            $display("FAIL num_width: M*F_CLK=%0d does not fit in %0d bits", NUM, CNT_W);
            $fatal(1);
        end
    end

    // RF source; toggles are offset by 3 ns so they never coincide with a clk edge.
    initial begin
        sig = 1'b0;
        #3;
        forever begin
            if (sig_half == 0) begin
                sig = 1'b0;
                #20;
            end else begin
                #(sig_half) sig = ~sig;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && f_valid) begin
            nvalid++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_f_valid: got {timeout,sat,f}=%0d,%0d,%0d with nothing expected",
                         timeout, sat, f);
            end else begin
                exp_v = exp_q.pop_front();
                if ({timeout, sat, f} !== exp_v) begin
                    fails++;
                    $display("FAIL result: got timeout=%0d sat=%0d f=%0d, expected timeout=%0d sat=%0d f=%0d",
                             timeout, sat, f, exp_v[15], exp_v[14], exp_v[13:0]);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic to, input logic st, input int fv);
        exp_q.push_back({to, st, 14'(fv)});
    endtask

    // Driver tasks
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int c = 0;
        @(negedge clk);
        while (state_dbg != s && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) check(name, state_dbg, s);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        @(negedge clk);
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, busy, 0);
    endtask

    task automatic set_period(input int half);
        sig_half = half;
        repeat (60) @(posedge clk);
    endtask

    initial begin
        int lat;
        int base;
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_f", f, 0);
        check("reset_f_valid", f_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_timeout_sat", {timeout, sat}, 0);
        check("reset_state", state_dbg, S_IDLE);

        // Ratio 10: n=80, 320000/80 = 4000; also window-close to f_valid latency.
        set_period(100);
        push_exp(1'b0, 1'b0, 4000);
        pulse_start();
        @(negedge clk);
        check("busy_after_start", busy, 1);
        wait_state("reach_div_a", S_DIV, 2000);
        lat = 0;
        while (!f_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("div_to_f_valid", lat, CNT_W + 1);
        wait_idle("idle_after_a", 100);
        check("queue_empty_a", exp_q.size(), 0);

        // Ratio 23: n=184, 320000/184 = 1739.
        set_period(230);
        push_exp(1'b0, 1'b0, 1739);
        pulse_start();
        wait_idle("idle_after_b", 2000);
        check("queue_empty_b", exp_q.size(), 0);

        // Dead signal: timeout 4096 cycles after ARM entry.
        set_period(0);
        push_exp(1'b1, 1'b0, 0);
        pulse_start();
        lat = 0;
        @(negedge clk);
        while (!f_valid && lat < 6000) begin
            lat++;
            @(negedge clk);
        end
        check("timeout_latency", lat, TIMEOUT_CYC);
        wait_idle("idle_after_c", 100);

        // Ratio 2: n=16, 20000 clips to 16383.
        set_period(20);
        push_exp(1'b0, 1'b1, 16383);
        pulse_start();
        wait_idle("idle_after_d", 2000);
        check("queue_empty_d", exp_q.size(), 0);

        // Continuous mode at ratio 50 (f=800); drop cont in the fourth MEAS.
        set_period(500);
        base = nvalid;
        repeat (4) push_exp(1'b0, 1'b0, 800);
        @(posedge clk);
        #1 cont = 1'b1;
        lat = 0;
        while (nvalid == base && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        check("rearm_after_f_valid", state_dbg, S_ARM);
        lat = 0;
        while (nvalid < base + 3 && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        wait_state("reach_meas_e", S_MEAS, 200);
        #1 cont = 1'b0;
        wait_idle("idle_after_e", 2000);
        check("cont_result_count", nvalid - base, 4);
        check("queue_empty_e", exp_q.size(), 0);

        // Reset mid-MEAS, then a clean measurement.
        set_period(100);
        pulse_start();
        wait_state("reach_meas_f", S_MEAS, 200);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_f", f, 0);
        check("rst_state", state_dbg, S_IDLE);
        base = nvalid;
        repeat (200) @(posedge clk);
        check("no_f_valid_after_rst", nvalid - base, 0);
        push_exp(1'b0, 1'b0, 4000);
        pulse_start();
        wait_idle("idle_after_f", 2000);
        check("queue_empty_final", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
